// File: rtl/addsub_pkg.sv
// Shared definitions for the sequential add/subtract unit: FSM state
// encoding, operation codes and the slice-count helper.
package addsub_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    BUSY = S_BUSY,
    DONE = S_DONE
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Number of CHUNK-bit slices needed to cover a WIDTH-bit operand
  function automatic int calc_nchunk(input int width, input int chunk);
    return (width + chunk - 1) / chunk;
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// CHUNK-bit ripple-carry adder slice with carry-in and carry-out.
module addsub_chunk
  import addsub_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o
);

  // Ripple the carry bit by bit from cin_i up to the slice MSB
  always_comb begin
    logic c;
    c     = cin_i;
    sum_o = '0;
    for (int i = 0; i < CHUNK; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c;
      c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    cout_o = c;
  end

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle add/subtract unit: one CHUNK-bit slice per cycle, carry
// chained through a register, valid/ready on both sides.
// Optional macro ADDSUB_OVF_EN enables the registered signed-overflow flag;
// without it ovf is tied low.
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = 33,
  parameter int CHUNK = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int              NCHUNK    = calc_nchunk(WIDTH, CHUNK);
  localparam int              IDXW      = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(NCHUNK - 1);
  localparam int              LAST_BITS = WIDTH % CHUNK;
  localparam bit              PARTIAL   = (LAST_BITS != 0);
  localparam int              CARRY_BIT = PARTIAL ? LAST_BITS : 0;

  state_e           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [CHUNK-1:0] a_slice, b_slice, sum_w;
  logic             cout_w;
  logic             slice_cout;

`ifdef ADDSUB_OVF_EN
  logic ovf_q, ovf_d;
`endif

  // Pick the operand slice addressed by the current slice index
  always_comb begin
    a_slice = '0;
    b_slice = '0;
    for (int j = 0; j < WIDTH; j++) begin
      if ((j / CHUNK) == int'(idx_q)) begin
        a_slice[j % CHUNK] = a_q[j];
        b_slice[j % CHUNK] = b_q[j];
      end
    end
  end

  addsub_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a_i    (a_slice),
    .b_i    (b_slice),
    .cin_i  (carry_q),
    .sum_o  (sum_w),
    .cout_o (cout_w)
  );

  // A short last slice has zero-padded upper bits, so the carry out of
  // bit WIDTH-1 lands in the first padded sum bit rather than cout_w
  always_comb begin
    slice_cout = cout_w;
    if (PARTIAL && (idx_q == LAST_IDX)) begin
      slice_cout = sum_w[CARRY_BIT];
    end
  end

  // Next-state logic: accept in IDLE, one slice per BUSY cycle, hold in DONE
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
`ifdef ADDSUB_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = (op == OP_ADD) ? b : ~b;
          carry_d = (op == OP_SUB);
          idx_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int j = 0; j < WIDTH; j++) begin
          if ((j / CHUNK) == int'(idx_q)) begin
            result_d[j] = sum_w[j % CHUNK];
          end
        end
        carry_d = slice_cout;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = DONE;
`ifdef ADDSUB_OVF_EN
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                    (result_d[WIDTH-1] != a_q[WIDTH-1]);
`endif
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial work
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

`ifdef ADDSUB_OVF_EN
  // Overflow flag, registered alongside the final result slice
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign cout      = carry_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Testbench for addsub_seq: four instances (33/8, 33/1, 33/33, 10/4)
// sharing operand buses, each with its own in_valid.
module tb_addsub_seq;

  logic        clock;
  logic        reset_n;
  logic [3:0]  inValid;
  logic        op;
  logic [32:0] a, b;
  logic        outReady;
  logic [3:0]  inReady, outValid, coutV, ovfV;
  logic [32:0] res0, res1, res2;
  logic [9:0]  res3;

  int checks   = 0;
  int failures = 0;
  int nch[4]   = '{5, 33, 1, 3};
  int wid[4]   = '{33, 33, 33, 10};

  typedef struct {
    bit          op;
    logic [32:0] a;
    logic [32:0] b;
    logic [32:0] res;
    bit          co;
    bit          ov;
  } vec_t;

  vec_t vecs[8];

  addsub_seq #(.WIDTH(33), .CHUNK(8)) dut0 (
    .clock(clock), .reset_n(reset_n), .in_valid(inValid[0]), .in_ready(inReady[0]),
    .op(op), .a(a), .b(b), .out_valid(outValid[0]), .out_ready(outReady),
    .result(res0), .cout(coutV[0]), .ovf(ovfV[0]));

  addsub_seq #(.WIDTH(33), .CHUNK(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .in_valid(inValid[1]), .in_ready(inReady[1]),
    .op(op), .a(a), .b(b), .out_valid(outValid[1]), .out_ready(outReady),
    .result(res1), .cout(coutV[1]), .ovf(ovfV[1]));

  addsub_seq #(.WIDTH(33), .CHUNK(33)) dut2 (
    .clock(clock), .reset_n(reset_n), .in_valid(inValid[2]), .in_ready(inReady[2]),
    .op(op), .a(a), .b(b), .out_valid(outValid[2]), .out_ready(outReady),
    .result(res2), .cout(coutV[2]), .ovf(ovfV[2]));

  addsub_seq #(.WIDTH(10), .CHUNK(4)) dut3 (
    .clock(clock), .reset_n(reset_n), .in_valid(inValid[3]), .in_ready(inReady[3]),
    .op(op), .a(a[9:0]), .b(b[9:0]), .out_valid(outValid[3]), .out_ready(outReady),
    .result(res3), .cout(coutV[3]), .ovf(ovfV[3]));

  // Free-running clock, 10 time units per period
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard time limit so the run always ends
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [32:0] getRes(input int d);
    case (d)
      0:       return res0;
      1:       return res1;
      2:       return res2;
      default: return {23'd0, res3};
    endcase
  endfunction

  function automatic bit ovfExp(input bit v);
`ifdef ADDSUB_OVF_EN
    return v;
`else
    return 1'b0 & v;
`endif
  endfunction

  // Reference: plain modular arithmetic and signed-range check
  function automatic void refModel(input int w, input bit opIn,
                                   input longint unsigned aIn, input longint unsigned bIn,
                                   output longint unsigned res, output bit co, output bit ov);
    longint unsigned m;
    longint          half, sa, sb, sr;
    m    = 64'd1 << w;
    half = longint'(m >> 1);
    if (opIn) begin
      res = (aIn + m - bIn) % m;
      co  = (aIn >= bIn);
    end else begin
      res = (aIn + bIn) % m;
      co  = ((aIn + bIn) >= m);
    end
    sa = (longint'(aIn) >= half) ? longint'(aIn) - longint'(m) : longint'(aIn);
    sb = (longint'(bIn) >= half) ? longint'(bIn) - longint'(m) : longint'(bIn);
    sr = opIn ? (sa - sb) : (sa + sb);
    ov = ovfExp((sr < -half) || (sr >= half));
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one operation on instance d, wait for the result, optionally release it
  task automatic applyStimulus(input int d, input bit opIn, input logic [32:0] aIn,
                               input logic [32:0] bIn, input bit releaseIt,
                               output logic [32:0] res, output bit co, output bit ov,
                               output int lat);
    int guard;
    guard = 0;
    while (!inReady[d] && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    checkOutput("in_ready before issue", 64'(inReady[d]), 64'd1);
    op         = opIn;
    a          = aIn;
    b          = bIn;
    inValid[d] = 1'b1;
    @(posedge clock);
    #1;
    inValid[d] = 1'b0;
    op = 1'($urandom());
    a  = {1'($urandom()), 32'($urandom())};
    b  = {1'($urandom()), 32'($urandom())};
    checkOutput("in_ready low after accept", 64'(inReady[d]), 64'd0);
    lat = 1;
    while (!outValid[d] && lat < 200) begin
      @(posedge clock);
      #1;
      lat++;
    end
    checkOutput("out_valid within budget", 64'(outValid[d]), 64'd1);
    res = getRes(d);
    co  = coutV[d];
    ov  = ovfV[d];
    if (releaseIt) begin
      outReady = 1'b1;
      @(posedge clock);
      #1;
      outReady = 1'b0;
      checkOutput("out_valid low after release", 64'(outValid[d]), 64'd0);
      checkOutput("in_ready high after release", 64'(inReady[d]), 64'd1);
    end
  endtask

  task automatic applyReset();
    inValid  = '0;
    outReady = 1'b0;
    reset_n  = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [32:0]     r;
    bit              c, v;
    int              lat, d, w;
    logic [63:0]     rnd;
    longint unsigned mask, aR, bR, expR;
    bit              expC, expV, opR;

    vecs[0] = '{1'b0, 33'h1_0000_0001, 33'h0_FFFF_FFFF, 33'h0_0000_0000, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 33'h0_0000_0005, 33'h0_0000_0007, 33'h1_FFFF_FFFE, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 33'h0_FFFF_FFFF, 33'h0_0000_0001, 33'h1_0000_0000, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 33'h0_0000_0000, 33'h0_0000_0000, 33'h0_0000_0000, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 33'h0_0000_0000, 33'h1_0000_0000, 33'h1_0000_0000, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 33'h1_FFFF_FFFF, 33'h1_FFFF_FFFF, 33'h1_FFFF_FFFE, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 33'h1_0000_0000, 33'h1_0000_0000, 33'h0_0000_0000, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 33'h1_2345_6789, 33'h0_1111_1111, 33'h1_1234_5678, 1'b1, 1'b0};

    op = 1'b0;
    a  = '0;
    b  = '0;
    applyReset();

    for (int i = 0; i < 4; i++) begin
      checkOutput("reset in_ready", 64'(inReady[i]), 64'd1);
      checkOutput("reset out_valid", 64'(outValid[i]), 64'd0);
      checkOutput("reset result", 64'(getRes(i)), 64'd0);
      checkOutput("reset cout", 64'(coutV[i]), 64'd0);
      checkOutput("reset ovf", 64'(ovfV[i]), 64'd0);
    end

    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, r, c, v, lat);
      checkOutput("vector result", 64'(r), 64'(vecs[i].res));
      checkOutput("vector cout", 64'(c), 64'(vecs[i].co));
      checkOutput("vector ovf", 64'(v), 64'(ovfExp(vecs[i].ov)));
      checkOutput("vector latency", 64'(lat), 64'd6);
    end

    applyStimulus(3, 1'b0, 33'h3FF, 33'h001, 1'b1, r, c, v, lat);
    checkOutput("w10 result", 64'(r), 64'd0);
    checkOutput("w10 cout", 64'(c), 64'd1);
    checkOutput("w10 ovf", 64'(v), 64'd0);
    checkOutput("w10 latency", 64'(lat), 64'd4);

    applyStimulus(0, 1'b0, 33'h0_0000_1234, 33'h0_0000_4321, 1'b0, r, c, v, lat);
    checkOutput("hold first result", 64'(r), 64'h5555);
    for (int k = 0; k < 5; k++) begin
      inValid[0] = 1'b1;
      a = 33'h0_0F0F_0F0F;
      b = 33'h1_0000_0003;
      @(posedge clock);
      #1;
      checkOutput("hold out_valid", 64'(outValid[0]), 64'd1);
      checkOutput("hold in_ready", 64'(inReady[0]), 64'd0);
      checkOutput("hold result", 64'(res0), 64'h5555);
    end
    inValid[0] = 1'b0;
    outReady   = 1'b1;
    @(posedge clock);
    #1;
    outReady = 1'b0;
    checkOutput("release out_valid", 64'(outValid[0]), 64'd0);
    checkOutput("release in_ready", 64'(inReady[0]), 64'd1);
    @(posedge clock);
    #1;
    checkOutput("no queued op in_ready", 64'(inReady[0]), 64'd1);
    checkOutput("no queued op out_valid", 64'(outValid[0]), 64'd0);

    op = 1'b0;
    a  = 33'h1_2345_6789;
    b  = 33'h0_0101_0101;
    inValid[0] = 1'b1;
    @(posedge clock);
    #1;
    inValid[0] = 1'b0;
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("midbusy reset out_valid", 64'(outValid[0]), 64'd0);
    checkOutput("midbusy reset result", 64'(res0), 64'd0);
    checkOutput("midbusy reset cout", 64'(coutV[0]), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    checkOutput("post reset in_ready", 64'(inReady[0]), 64'd1);
    applyStimulus(0, 1'b0, 33'h1_2345_6789, 33'h0_0101_0101, 1'b1, r, c, v, lat);
    checkOutput("post reset result", 64'(r), 64'h1_2446_688A);
    checkOutput("post reset cout", 64'(c), 64'd0);

    for (int i = 0; i < 1000; i++) begin
      d    = i % 4;
      w    = wid[d];
      mask = (64'd1 << w) - 1;
      rnd  = {$urandom(), $urandom()};
      aR   = rnd & mask;
      rnd  = {$urandom(), $urandom()};
      bR   = rnd & mask;
      case ($urandom_range(0, 7))
        0:       aR = mask;
        1:       aR = 64'd1 << (w - 1);
        2:       bR = mask;
        3:       bR = 64'd1 << (w - 1);
        default: ;
      endcase
      opR = 1'($urandom());
      refModel(w, opR, aR, bR, expR, expC, expV);
      applyStimulus(d, opR, 33'(aR), 33'(bR), 1'b1, r, c, v, lat);
      checkOutput("random result", 64'(r), expR);
      checkOutput("random cout", 64'(c), 64'(expC));
      checkOutput("random ovf", 64'(v), 64'(expV));
      checkOutput("random latency", 64'(lat), 64'(nch[d] + 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
